// File: rtl/freelist_ctrl_if.sv
// Rename/freelist handshake bundle for freelist_ctrl: allocation request/grant,
// retire free, and the freelist clear/push strobes.
interface freelist_ctrl_if #(
    parameter int unsigned PHY_WIDTH = 6,
    parameter int unsigned FW        = 5
);
    logic [1:0]           rename_req;
    logic [FW:0]          num_free;
    logic                 retire_valid;
    logic [PHY_WIDTH-1:0] rd_phy_old;
    logic [1:0]           alloc_valid;
    logic                 rename_stall;
    logic                 fl_clear;
    logic                 fl_push;
    logic [PHY_WIDTH-1:0] fl_push_reg;

    modport master (
        input  rename_req, num_free, retire_valid, rd_phy_old,
        output alloc_valid, rename_stall, fl_clear, fl_push, fl_push_reg
    );

    modport slave (
        output rename_req, num_free, retire_valid, rd_phy_old,
        input  alloc_valid, rename_stall, fl_clear, fl_push, fl_push_reg
    );
endinterface

// File: rtl/freelist_ctrl.sv
// Freelist sequencer: grants rename allocations, forwards retire frees, and rebuilds the
// freelist from the committed-busy snapshot after a flush. Optional counters: FREELIST_CTRL_STATS_EN.
module freelist_ctrl #(
    parameter int unsigned PHY_REGS  = 64,
    parameter int unsigned PHY_WIDTH = 6,
    parameter int unsigned FREE_REG  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [PHY_REGS-1:0] committed_busy,
    freelist_ctrl_if.master     fl,
    output logic                recovering,
    output logic                recover_done,
    output logic                drop_err
`ifdef FREELIST_CTRL_STATS_EN
    ,
    output logic [31:0]         stat_flushes,
    output logic [31:0]         stat_stall_cycles,
    output logic [31:0]         stat_drops
`endif
);

    localparam int unsigned          FW       = $clog2(FREE_REG);
    localparam logic [FW:0]          NF_ONE   = (FW+1)'(1);
    localparam logic [FW:0]          NF_TWO   = (FW+1)'(2);
    localparam logic [PHY_WIDTH-1:0] IDX_FIRST = PHY_WIDTH'(1);
    localparam logic [PHY_WIDTH-1:0] IDX_LAST  = PHY_WIDTH'(PHY_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCAN,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [PHY_WIDTH-1:0] idx, idx_nxt;
    logic [PHY_REGS-1:0]  snap;
    logic                 retire_drop;

    // A retire arriving while the freelist is being rebuilt has nowhere to go.
    assign retire_drop = fl.retire_valid && ((state != IDLE) || flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= IDX_FIRST;
            snap     <= '0;
            drop_err <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (flush)
                snap <= committed_busy;
            if (retire_drop)
                drop_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (flush) begin
            state_nxt = CLEAR;
            idx_nxt   = IDX_FIRST;
        end else begin
            unique case (state)
                IDLE:  state_nxt = IDLE;
                CLEAR: begin
                    state_nxt = SCAN;
                    idx_nxt   = IDX_FIRST;
                end
                SCAN: begin
                    if (idx == IDX_LAST)
                        state_nxt = DONE;
                    else
                        idx_nxt = idx + IDX_FIRST;
                end
                DONE:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        fl.alloc_valid  = 2'b00;
        fl.rename_stall = 1'b0;
        fl.fl_clear     = 1'b0;
        fl.fl_push      = 1'b0;
        fl.fl_push_reg  = '0;
        recovering      = 1'b0;
        recover_done    = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (fl.rename_req)
                    2'b11: begin
                        if (fl.num_free >= NF_TWO)
                            fl.alloc_valid = 2'b11;
                        else if (fl.num_free == NF_ONE)
                            fl.alloc_valid = 2'b01;
                    end
                    2'b01, 2'b10: begin
                        if (fl.num_free >= NF_ONE)
                            fl.alloc_valid = fl.rename_req;
                    end
                    default: fl.alloc_valid = 2'b00;
                endcase
                fl.rename_stall = |(fl.rename_req & ~fl.alloc_valid);
                if (fl.retire_valid && !flush) begin
                    fl.fl_push     = 1'b1;
                    fl.fl_push_reg = fl.rd_phy_old;
                end
            end
            CLEAR: begin
                recovering      = 1'b1;
                fl.rename_stall = 1'b1;
                fl.fl_clear     = 1'b1;
            end
            SCAN: begin
                recovering      = 1'b1;
                fl.rename_stall = 1'b1;
                fl.fl_push      = ~snap[idx];
                fl.fl_push_reg  = idx;
            end
            DONE: begin
                recovering      = 1'b1;
                fl.rename_stall = 1'b1;
                recover_done    = 1'b1;
            end
            default: begin
                recovering      = 1'b1;
                fl.rename_stall = 1'b1;
            end
        endcase
    end

`ifdef FREELIST_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flushes      <= '0;
            stat_stall_cycles <= '0;
            stat_drops        <= '0;
        end else begin
            if (flush && (stat_flushes != '1))
                stat_flushes <= stat_flushes + 32'd1;
            if (fl.rename_stall && (stat_stall_cycles != '1))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            if (retire_drop && (stat_drops != '1))
                stat_drops <= stat_drops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// Scoreboard bench for freelist_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops them and also flags any unexpected clear/push/done strobe.
module tb_freelist_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [63:0] committed_busy;
    logic        recovering;
    logic        recover_done;
    logic        drop_err;
`ifdef FREELIST_CTRL_STATS_EN
    logic [31:0] stat_flushes;
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_drops;
`endif

    freelist_ctrl_if #(.PHY_WIDTH(6), .FW(5)) fl_if ();

    freelist_ctrl #(.PHY_REGS(64), .PHY_WIDTH(6), .FREE_REG(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .committed_busy (committed_busy),
        .fl             (fl_if),
        .recovering     (recovering),
        .recover_done   (recover_done),
        .drop_err       (drop_err)
`ifdef FREELIST_CTRL_STATS_EN
        ,
        .stat_flushes      (stat_flushes),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_drops        (stat_drops)
`endif
    );

    typedef enum int {K_PUSH, K_CLEAR, K_DONE, K_GRANT, K_DROP, K_ZERO} kind_t;
    typedef struct {
        int unsigned cyc;
        kind_t       kind;
        logic [7:0]  val;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Sorted insert so expectations may be queued out of cycle order.
    function automatic void expect_ev(input int unsigned c, input kind_t k, input logic [7:0] v);
        exp_t        e;
        int unsigned i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = q.size();
        while (i > 0 && q[i-1].cyc > c) i--;
        q.insert(i, e);
    endfunction

    // CLEAR at cycle c, scan index k at cycle c+k, DONE at c+64 when the scan completes.
    function automatic void expect_rebuild(input int unsigned c, input logic [63:0] bm,
                                           input int unsigned last, input bit with_done);
        expect_ev(c, K_CLEAR, 8'd0);
        for (int unsigned k = 1; k <= last; k++)
            if (!bm[k]) expect_ev(c + k, K_PUSH, 8'(k));
        if (with_done) expect_ev(c + 64, K_DONE, 8'd0);
    endfunction

    always @(negedge clk) begin
        exp_t       e;
        logic       ep, ec, ed, eg, edr, ez;
        logic [7:0] ereg, egv;
        logic       edrv;
        ep = 0; ec = 0; ed = 0; eg = 0; edr = 0; ez = 0;
        ereg = '0; egv = '0; edrv = 0;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expectation kind=%0d actual_cyc=%0d required_cyc=%0d", e.kind, cyc, e.cyc);
            end else begin
                case (e.kind)
                    K_PUSH:  begin ep = 1; ereg = e.val; end
                    K_CLEAR: ec = 1;
                    K_DONE:  ed = 1;
                    K_GRANT: begin eg = 1; egv = e.val; end
                    K_DROP:  begin edr = 1; edrv = e.val[0]; end
                    K_ZERO:  ez = 1;
                    default: ;
                endcase
            end
        end
        if (fl_if.fl_push || ep)
            chk("push", {25'd0, fl_if.fl_push, fl_if.fl_push_reg}, {25'd0, ep, ereg[5:0]});
        if (fl_if.fl_clear || ec)
            chk("clear", {31'd0, fl_if.fl_clear}, {31'd0, ec});
        if (recover_done || ed)
            chk("recover_done", {31'd0, recover_done}, {31'd0, ed});
        if (eg)
            chk("grant{rec,stall,alloc}",
                {28'd0, recovering, fl_if.rename_stall, fl_if.alloc_valid}, {24'd0, egv});
        if (edr)
            chk("drop_err", {31'd0, drop_err}, {31'd0, edrv});
        if (ez)
            chk("all_outputs_zero",
                {18'd0, fl_if.alloc_valid, fl_if.rename_stall, fl_if.fl_clear, fl_if.fl_push,
                 fl_if.fl_push_reg, recovering, recover_done, drop_err}, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    logic [1:0]  t2_req [9] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11};
    logic [5:0]  t2_nf  [9] = '{6'd1, 6'd0, 6'd5, 6'd0, 6'd0, 6'd1, 6'd32, 6'd2, 6'd0};
    logic [3:0]  t2_exp [9] = '{4'b0101, 4'b0100, 4'b0011, 4'b0000, 4'b0100, 4'b0010,
                                4'b0001, 4'b0011, 4'b0100};

    initial begin
        int unsigned f;
        logic [63:0] bm;

        rst = 1'b1;
        flush = 1'b0;
        committed_busy = '0;
        fl_if.rename_req = 2'b00;
        fl_if.num_free = '0;
        fl_if.retire_valid = 1'b0;
        fl_if.rd_phy_old = '0;
        step();
        expect_ev(cyc, K_ZERO, 8'd0);
        step();
        rst = 1'b0;
        expect_ev(cyc, K_ZERO, 8'd0);
        step();

        // Allocation grant table.
        for (int i = 0; i < 9; i++) begin
            fl_if.rename_req = t2_req[i];
            fl_if.num_free = t2_nf[i];
            expect_ev(cyc, K_GRANT, {4'd0, t2_exp[i]});
            step();
        end

        // Retire forwarding in IDLE, concurrent with an allocation; p0 forwarded unchanged.
        fl_if.rename_req = 2'b11;
        fl_if.num_free = 6'd3;
        fl_if.retire_valid = 1'b1;
        fl_if.rd_phy_old = 6'd40;
        expect_ev(cyc, K_PUSH, 8'd40);
        expect_ev(cyc, K_GRANT, 8'b0011);
        expect_ev(cyc, K_DROP, 8'd0);
        step();
        fl_if.rd_phy_old = 6'd0;
        fl_if.rename_req = 2'b00;
        expect_ev(cyc, K_PUSH, 8'd0);
        step();
        fl_if.retire_valid = 1'b0;
        step();

        // Full rebuild with p0..p31 committed; a retire during SCAN is dropped.
        fl_if.rename_req = 2'b11;
        fl_if.num_free = 6'd10;
        bm = 64'h0000_0000_FFFF_FFFF;
        committed_busy = bm;
        flush = 1'b1;
        f = cyc;
        expect_ev(f, K_GRANT, 8'b0011);
        expect_rebuild(f + 1, bm, 63, 1'b1);
        expect_ev(f + 1, K_GRANT, 8'b1100);
        expect_ev(f + 65, K_GRANT, 8'b1100);
        expect_ev(f + 66, K_GRANT, 8'b0011);
        step();
        flush = 1'b0;
        committed_busy = '0;
        while (cyc < f + 20) step();
        fl_if.retire_valid = 1'b1;
        fl_if.rd_phy_old = 6'd40;
        expect_ev(f + 21, K_DROP, 8'd1);
        step();
        fl_if.retire_valid = 1'b0;
        while (cyc < f + 67) step();

        // Reflush at SCAN idx=10 restarts with the new snapshot, single recover_done.
        fl_if.rename_req = 2'b00;
        bm = 64'hAAAA_AAAA_AAAA_AAAA;
        committed_busy = bm;
        flush = 1'b1;
        f = cyc;
        expect_rebuild(f + 1, bm, 10, 1'b0);
        step();
        flush = 1'b0;
        committed_busy = '0;
        while (cyc < f + 11) step();
        bm = 64'hFFFF_0000_FFFF_FFFF;
        committed_busy = bm;
        flush = 1'b1;
        expect_ev(cyc, K_GRANT, 8'b1100);
        expect_rebuild(cyc + 1, bm, 63, 1'b1);
        f = cyc;
        step();
        flush = 1'b0;
        committed_busy = '0;
        while (cyc < f + 67) step();

        // Asynchronous reset at SCAN idx=17 where a push would otherwise occur.
        bm = 64'hFFFF_FFFF_FFFF_FFFF;
        bm[17] = 1'b0;
        bm[18] = 1'b0;
        committed_busy = bm;
        flush = 1'b1;
        f = cyc;
        expect_rebuild(f + 1, bm, 16, 1'b0);
        expect_ev(f + 17, K_DROP, 8'd1);
        step();
        flush = 1'b0;
        committed_busy = '0;
        while (cyc < f + 18) step();
        rst = 1'b1;
        expect_ev(cyc, K_ZERO, 8'd0);
        step();
        rst = 1'b0;
        for (int unsigned k = 0; k < 5; k++) expect_ev(cyc + k, K_ZERO, 8'd0);
        repeat (7) step();

        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL unconsumed_expectation kind=%0d actual=none required_cyc=%0d", e.kind, e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
